// File: rtl/gcd_ctrl_if.sv
// Handshake and subtractor bundle for the GCD sequencer.
// master: command source, result consumer and subtractor; slave: the controller.
interface gcd_ctrl_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ITER_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_a;
   logic [WIDTH-1:0]  in_b;
   logic [WIDTH-1:0]  sub_a;
   logic [WIDTH-1:0]  sub_b;
   logic [WIDTH-1:0]  sub_res;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_gcd;
   logic [ITER_W-1:0] out_iter;
   logic              busy;

   modport master (
      output in_valid, in_a, in_b, sub_res, out_ready,
      input  in_ready, sub_a, sub_b, out_valid, out_gcd, out_iter, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, sub_res, out_ready,
      output in_ready, sub_a, sub_b, out_valid, out_gcd, out_iter, busy
   );
endinterface

// File: rtl/gcd_ctrl.sv
// Subtraction-based Euclid GCD sequencer: accepts an operand pair, steps an external
// subtractor once per cycle and returns the GCD with the number of subtract steps taken.
module gcd_ctrl #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ITER_W = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   gcd_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  gcd_q, gcd_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [ITER_W-1:0] out_iter_q, out_iter_d;
   logic [ITER_W-1:0] iter_inc;
   logic [WIDTH-1:0]  sub_a_c;
   logic [WIDTH-1:0]  sub_b_c;

   // Saturating step count: holds at all-ones instead of wrapping.
   assign iter_inc = (iter_q == {ITER_W{1'b1}}) ? iter_q : iter_q + ITER_W'(1);

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      gcd_d      = gcd_q;
      iter_d     = iter_q;
      out_iter_d = out_iter_q;
      sub_a_c    = '0;
      sub_b_c    = '0;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               a_d    = bus.in_a;
               b_d    = bus.in_b;
               iter_d = '0;
               if ((bus.in_a == '0) || (bus.in_b == '0)) begin
                  gcd_d      = (bus.in_a == '0) ? bus.in_b : bus.in_a;
                  out_iter_d = '0;
                  state_d    = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            // Larger operand is always the minuend, so the subtractor never underflows.
            if (a_q > b_q) begin
               sub_a_c = a_q;
               sub_b_c = b_q;
               a_d     = bus.sub_res;
               iter_d  = iter_inc;
            end else if (a_q < b_q) begin
               sub_a_c = b_q;
               sub_b_c = a_q;
               b_d     = bus.sub_res;
               iter_d  = iter_inc;
            end else begin
               gcd_d      = a_q;
               out_iter_d = iter_q;
               state_d    = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         gcd_q      <= '0;
         iter_q     <= '0;
         out_iter_q <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         gcd_q      <= gcd_d;
         iter_q     <= iter_d;
         out_iter_q <= out_iter_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.busy      = (state_q != StIdle);
   assign bus.out_gcd   = gcd_q;
   assign bus.out_iter  = out_iter_q;
   assign bus.sub_a     = sub_a_c;
   assign bus.sub_b     = sub_b_c;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: directed jobs with literal expectations plus a per-cycle compare
// against an arithmetic Euclid model; a second instance with a 2-bit counter checks saturation.
module tb_gcd_ctrl;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   gcd_ctrl_if #(.WIDTH(32), .ITER_W(32)) bus ();
   gcd_ctrl_if #(.WIDTH(32), .ITER_W(2))  bus2 ();

   gcd_ctrl #(.WIDTH(32), .ITER_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   gcd_ctrl #(.WIDTH(32), .ITER_W(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   assign bus.sub_res    = bus.sub_a - bus.sub_b;
   assign bus2.sub_res   = bus2.sub_a - bus2.sub_b;
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_a      = bus.in_a;
   assign bus2.in_b      = bus.in_b;
   assign bus2.out_ready = bus.out_ready;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   function automatic int euclid_steps(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (a != b && n < 10000) begin
         if (a > b) a = a - b;
         else b = b - a;
         n++;
      end
      return n;
   endfunction

   function automatic logic [31:0] euclid_gcd(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 10000 && a != b; i++) begin
         if (a > b) a = a - b;
         else b = b - a;
      end
      return a;
   endfunction

   function automatic void step_pair(input logic [31:0] a, input logic [31:0] b, input int k,
                                     output logic [31:0] sa, output logic [31:0] sb);
      for (int i = 0; i < k; i++) begin
         if (a > b) a = a - b;
         else b = b - a;
      end
      sa = (a > b) ? a : b;
      sb = (a > b) ? b : a;
   endfunction

   logic        m_busy;
   logic        m_valid;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [31:0] m_gcd;
   logic [31:0] m_iter;
   int          m_k;
   int          m_n;

   // m_k counts cycles since accept; the result appears after m_n steps plus the equal compare.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_a     <= '0;
         m_b     <= '0;
         m_gcd   <= '0;
         m_iter  <= '0;
         m_k     <= 0;
         m_n     <= 0;
      end else if (!m_busy) begin
         if (bus.in_valid) begin
            m_busy <= 1'b1;
            m_a    <= bus.in_a;
            m_b    <= bus.in_b;
            m_k    <= 0;
            m_n    <= 0;
            if (bus.in_a == 0 || bus.in_b == 0) begin
               m_valid <= 1'b1;
               m_gcd   <= (bus.in_a == 0) ? bus.in_b : bus.in_a;
               m_iter  <= '0;
            end else begin
               m_n <= euclid_steps(bus.in_a, bus.in_b);
            end
         end
      end else if (m_valid) begin
         if (bus.out_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
         end
      end else begin
         m_k <= m_k + 1;
         if (m_k == m_n) begin
            m_valid <= 1'b1;
            m_gcd   <= euclid_gcd(m_a, m_b);
            m_iter  <= 32'(m_n);
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] sa;
      logic [31:0] sb;
      if (rst_n) chk("m_in_ready", 32'(bus.in_ready), 32'(!m_busy));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("m_busy", 32'(bus.busy), 32'(m_busy));
      chk("m_out_gcd", bus.out_gcd, m_gcd);
      chk("m_out_iter", bus.out_iter, m_iter);
      if (m_busy && !m_valid) begin
         if (m_k < m_n) begin
            step_pair(m_a, m_b, m_k, sa, sb);
            chk("m_sub_a", bus.sub_a, sa);
            chk("m_sub_b", bus.sub_b, sb);
         end
      end else begin
         chk("m_sub_a_idle", bus.sub_a, 32'd0);
         chk("m_sub_b_idle", bus.sub_b, 32'd0);
      end
   end

   // ---------------- directed stimulus ----------------
   logic [31:0] exp_sa[$];
   logic [31:0] exp_sb[$];

   // elat counts clock edges after the accepting edge until out_valid is seen.
   task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eg,
                          input logic [31:0] ei, input int elat, input int hold,
                          input logic [31:0] esat);
      int lat;
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = (hold == 0);
      chk("accept_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         if (lat < exp_sa.size()) begin
            chk("step_sub_a", bus.sub_a, exp_sa[lat]);
            chk("step_sub_b", bus.sub_b, exp_sb[lat]);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(elat));
      chk("gcd", bus.out_gcd, eg);
      chk("iter", bus.out_iter, ei);
      chk("sat_iter", 32'(bus2.out_iter), esat);
      chk("sat_gcd", bus2.out_gcd, eg);
      chk("ready_low_done", 32'(bus.in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.in_a     = 32'd99 + 32'(h);
         bus.in_b     = 32'd33;
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_gcd", bus.out_gcd, eg);
         chk("hold_iter", bus.out_iter, ei);
         chk("hold_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("valid_drop", 32'(bus.out_valid), 32'd0);
      chk("ready_back", 32'(bus.in_ready), 32'd1);
      exp_sa.delete();
      exp_sb.delete();
   endtask

   initial begin
      n_pass        = 0;
      n_total       = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_gcd", bus.out_gcd, 32'd0);
      chk("rst_iter", bus.out_iter, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.in_ready), 32'd1);

      run_job(32'd12, 32'd8, 32'd4, 32'd2, 3, 0, 32'd2);
      exp_sa = '{32'd48, 32'd30, 32'd18, 32'd12};
      exp_sb = '{32'd18, 32'd18, 32'd12, 32'd6};
      run_job(32'd48, 32'd18, 32'd6, 32'd4, 5, 0, 32'd3);
      run_job(32'd7, 32'd0, 32'd7, 32'd0, 0, 0, 32'd0);
      run_job(32'd0, 32'd9, 32'd9, 32'd0, 0, 0, 32'd0);
      run_job(32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 32'd0);
      run_job(32'd5, 32'd5, 32'd5, 32'd0, 1, 0, 32'd0);
      run_job(32'd5, 32'd1, 32'd1, 32'd4, 5, 0, 32'd3);
      run_job(32'd12, 32'd8, 32'd4, 32'd2, 3, 5, 32'd2);

      // Abort a job with reset during its second calculation cycle.
      bus.in_valid = 1'b1;
      bus.in_a     = 32'd48;
      bus.in_b     = 32'd18;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_gcd", bus.out_gcd, 32'd0);
      chk("abort_iter", bus.out_iter, 32'd0);
      chk("abort_sub_a", bus.sub_a, 32'd0);
      chk("abort_sub_b", bus.sub_b, 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_job(32'd21, 32'd14, 32'd7, 32'd2, 3, 0, 32'd2);

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
